// File: rtl/interp_pkg.sv
// Shared types and constants for the subpixel-interpolation fetch path.
package interp_pkg;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_REQ,
    ST_WAIT,
    ST_LOAD,
    ST_FILTER,
    ST_DONE
  } fetch_state_e;

  localparam int WIN_ROWS      = 15;
  localparam int BLK_ROWS      = 8;
  localparam int TAP_PAD       = 3;
  localparam int BEATS_PER_ROW = 2;
  localparam int PIX_W         = 8;

  // One memory word carries eight pixels; rows are indexed 0..WIN_ROWS-1.
  localparam int WORD_W = 8 * PIX_W;
  localparam int ROW_W  = 4;

endpackage

// File: rtl/interp_fetch_ctrl_if.sv
// Pixel-memory read port: single outstanding request, variable-latency response.
interface interp_fetch_ctrl_if
  import interp_pkg::*;
#(
  parameter int ADDR_W = 16
) ();

  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic              mem_valid;
  logic [WORD_W-1:0] mem_data;

  modport master (
    output mem_req,
    output mem_addr,
    input  mem_valid,
    input  mem_data
  );

  modport slave (
    input  mem_req,
    input  mem_addr,
    output mem_valid,
    output mem_data
  );

endinterface

// File: rtl/interp_fetch_ctrl.sv
// Fetches the reference window for one 8x8 interpolation job into shift_reg,
// then kicks the 8-tap filter and reports completion.
module interp_fetch_ctrl
  import interp_pkg::*;
#(
  parameter int ADDR_W     = 16,
  parameter int ROW_STRIDE = 2
) (
  input  logic                   clock,
  input  logic                   reset_L,
  input  logic                   start,
  input  logic [ADDR_W-1:0]      base_addr,
  input  logic [1:0]             frac_x,
  input  logic [1:0]             frac_y,
  output logic                   busy,
  output logic                   done,
  interp_fetch_ctrl_if.master    mem,
  output logic                   load_L,
  output logic [WORD_W-1:0]      pix_out,
  output logic [7:0]             sel,
  output logic                   flt_start,
  input  logic                   flt_done
);

  localparam logic [ROW_W-1:0]  ROW_FIRST_WIN = '0;
  localparam logic [ROW_W-1:0]  ROW_LAST_WIN  = ROW_W'(WIN_ROWS - 1);
  localparam logic [ROW_W-1:0]  ROW_FIRST_BLK = ROW_W'(TAP_PAD);
  localparam logic [ROW_W-1:0]  ROW_LAST_BLK  = ROW_W'(TAP_PAD + BLK_ROWS - 1);
  localparam logic [ADDR_W-1:0] STRIDE        = ADDR_W'(ROW_STRIDE);
  localparam logic [ADDR_W-1:0] BLK_SKIP      = ADDR_W'(TAP_PAD * ROW_STRIDE);
  localparam logic              LAST_BEAT     = 1'(BEATS_PER_ROW - 1);

  fetch_state_e      state_q, state_d;
  logic [ROW_W-1:0]  row_q, row_last_q;
  logic              beat_q;
  logic [ADDR_W-1:0] row_base_q;
  logic [1:0]        fx_q, fy_q;
  logic              flt_entry_q;

  logic accept;
  logic row_end;
  logic win_end;

  // row_base_q tracks base + row*ROW_STRIDE; the beat offset is added here.
  assign mem.mem_addr = row_base_q + ADDR_W'(beat_q);

  assign accept  = (state_q == ST_IDLE) && start;
  assign row_end = (state_q == ST_LOAD) && (beat_q == LAST_BEAT);
  assign win_end = row_end && (row_q == row_last_q);

  always_ff @(posedge clock or negedge reset_L) begin
    if (!reset_L) begin
      state_q <= ST_IDLE;
    end else begin
      // NOTE: non-blocking so every register samples pre-edge values, independent of block order.
      state_q <= state_d;
    end
  end

  always_comb begin
    // NOTE: every output gets a default first so no path can infer a latch.
    state_d       = state_q;
    busy          = (state_q != ST_IDLE);
    done          = (state_q == ST_DONE);
    mem.mem_req   = (state_q == ST_REQ);
    load_L        = (state_q != ST_LOAD);
    flt_start     = (state_q == ST_FILTER) && flt_entry_q;

    unique case (state_q)
      ST_IDLE:   if (start) state_d = ST_REQ;
      ST_REQ:    state_d = ST_WAIT;
      ST_WAIT:   if (mem.mem_valid) state_d = ST_LOAD;
      ST_LOAD:   state_d = win_end ? ST_FILTER : ST_REQ;
      ST_FILTER: if (flt_done) state_d = ST_DONE;
      ST_DONE:   state_d = ST_IDLE;
      default:   state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock or negedge reset_L) begin
    if (!reset_L) begin
      row_q       <= '0;
      row_last_q  <= '0;
      beat_q      <= 1'b0;
      row_base_q  <= '0;
      fx_q        <= '0;
      fy_q        <= '0;
      pix_out     <= '0;
      sel         <= '0;
      flt_entry_q <= 1'b0;
    end else begin
      flt_entry_q <= 1'b0;

      if (accept) begin
        fx_q   <= frac_x;
        fy_q   <= frac_y;
        beat_q <= 1'b0;
        // Integer-pel vertical position skips the top tap padding rows entirely.
        if (frac_y != 2'd0) begin
          row_q      <= ROW_FIRST_WIN;
          row_last_q <= ROW_LAST_WIN;
          row_base_q <= base_addr;
        end else begin
          row_q      <= ROW_FIRST_BLK;
          row_last_q <= ROW_LAST_BLK;
          row_base_q <= base_addr + BLK_SKIP;
        end
      end

      if ((state_q == ST_WAIT) && mem.mem_valid) begin
        pix_out <= mem.mem_data;
      end

      if (state_q == ST_LOAD) begin
        if (row_end) begin
          beat_q     <= 1'b0;
          row_q      <= row_q + 1'b1;
          row_base_q <= row_base_q + STRIDE;
        end else begin
          beat_q <= 1'b1;
        end
      end

      // sel is loaded on the edge into FILTER so it is already valid on the entry cycle.
      if (win_end) begin
        flt_entry_q <= 1'b1;
        sel         <= {4'b0000, fy_q, fx_q};
      end
    end
  end

endmodule

// File: tb/tb_interp_fetch_ctrl.sv
// Directed bench for interp_fetch_ctrl with a behavioural memory and filter responder.
module tb_interp_fetch_ctrl;
  import interp_pkg::*;

  localparam int ADDR_W     = 16;
  localparam int ROW_STRIDE = 2;

  logic        clock = 1'b0;
  logic        reset_L;
  logic        start;
  logic [15:0] base_addr;
  logic [1:0]  frac_x, frac_y;
  logic        busy, done, load_L, flt_start, flt_done;
  logic [63:0] pix_out;
  logic [7:0]  sel;

  interp_fetch_ctrl_if #(.ADDR_W(ADDR_W)) mem_bus ();

  interp_fetch_ctrl #(.ADDR_W(ADDR_W), .ROW_STRIDE(ROW_STRIDE)) dut (
    .clock(clock), .reset_L(reset_L), .start(start), .base_addr(base_addr),
    .frac_x(frac_x), .frac_y(frac_y), .busy(busy), .done(done), .mem(mem_bus),
    .load_L(load_L), .pix_out(pix_out), .sel(sel), .flt_start(flt_start),
    .flt_done(flt_done)
  );

  initial forever #5 clock = ~clock;

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  always @(posedge clock) cyc <= cyc + 1;

  // Stimulus knobs and logs written by the responder process.
  int          lat_mode = 0;
  int          spur_idx = -1;
  int          flt_delay = 0;
  logic [15:0] req_log[$];
  int          req_cyc[$];
  logic [63:0] load_log[$];
  int          load_cyc[$];
  int          overlap_cnt, flt_cnt, done_cnt;
  int          flt_start_cyc, flt_done_cyc, done_cyc, start_cyc;
  logic [7:0]  sel_at_flt;
  logic        busy_after_start, busy_after_done;

  function automatic logic [63:0] mem_word(logic [15:0] a);
    return {a, a ^ 16'h5A5A, ~a, a + 16'h1357};
  endfunction

  function automatic logic [15:0] exp_addr(logic [15:0] base, logic [1:0] fy, int i);
    int row;
    row = ((fy != 2'd0) ? 0 : 3) + i / 2;
    return 16'(int'(base) + row * ROW_STRIDE + (i % 2));
  endfunction

  function automatic int lat_for(int idx);
    case (lat_mode)
      0:       return 1;
      1:       return (idx % 3 == 0) ? 1 : ((idx % 3 == 1) ? 4 : 7);
      default: return 7;
    endcase
  endfunction

  // Memory + filter responder and event logger, all on the falling edge.
  initial begin
    bit          pend = 0;
    int          pend_cnt = 0;
    logic [15:0] pend_addr = '0;
    bit          flt_pend = 0;
    int          flt_left = 0;
    mem_bus.mem_valid = 1'b0;
    mem_bus.mem_data  = '0;
    flt_done = 1'b0;
    forever begin
      @(negedge clock);
      mem_bus.mem_valid = 1'b0;
      flt_done = 1'b0;
      if (mem_bus.mem_req && pend) overlap_cnt++;
      if (pend) begin
        pend_cnt--;
        if (pend_cnt == 0) begin
          mem_bus.mem_valid = 1'b1;
          mem_bus.mem_data  = mem_word(pend_addr);
          pend = 0;
        end
      end
      if (mem_bus.mem_req) begin
        if (req_log.size() == spur_idx) begin
          mem_bus.mem_valid = 1'b1;
          mem_bus.mem_data  = 64'hDEAD_BEEF_0BAD_F00D;
        end
        req_log.push_back(mem_bus.mem_addr);
        req_cyc.push_back(cyc);
        pend      = 1;
        pend_addr = mem_bus.mem_addr;
        pend_cnt  = lat_for(req_log.size() - 1);
      end
      if (!load_L) begin
        load_log.push_back(pix_out);
        load_cyc.push_back(cyc);
      end
      if (flt_start) begin
        flt_cnt++;
        flt_start_cyc = cyc;
        sel_at_flt    = sel;
        flt_pend      = 1;
        flt_left      = flt_delay;
      end
      if (flt_pend) begin
        if (flt_left == 0) begin
          flt_done     = 1'b1;
          flt_done_cyc = cyc;
          flt_pend     = 0;
        end else begin
          flt_left--;
        end
      end
      if (cyc == done_cyc + 1) busy_after_done = busy;
      if (done) begin
        done_cnt++;
        done_cyc = cyc;
      end
    end
  end

  task automatic launch(logic [15:0] base, logic [1:0] fx, logic [1:0] fy);
    @(negedge clock);
    req_log.delete(); req_cyc.delete(); load_log.delete(); load_cyc.delete();
    overlap_cnt = 0; flt_cnt = 0; done_cnt = 0;
    flt_start_cyc = -10; flt_done_cyc = -10; done_cyc = -10;
    start = 1'b1; base_addr = base; frac_x = fx; frac_y = fy;
    start_cyc = cyc;
    @(negedge clock);
    start = 1'b0;
    busy_after_start = busy;
  endtask

  task automatic run_job(logic [15:0] base, logic [1:0] fx, logic [1:0] fy, int fd, bit poke);
    flt_delay = fd;
    launch(base, fx, fy);
    for (int k = 0; k < 3000 && done_cnt == 0; k++) begin
      @(negedge clock);
      if (poke && (k == 10 || k == 40)) begin
        start = 1'b1; base_addr = 16'hBEEF; frac_y = 2'd0;
      end else begin
        start = 1'b0;
      end
    end
    start = 1'b0;
    total++;
    if (done_cnt == 0) begin
      bad++;
      $display("FAIL job_timeout: base=%h got no done within cycle budget", base);
    end
    repeat (3) @(negedge clock);
  endtask

  task automatic test_reset();
    reset_L = 1'b0; start = 1'b0; base_addr = '0; frac_x = '0; frac_y = '0;
    repeat (3) @(negedge clock);
    total++; if (busy !== 1'b0)   begin bad++; $display("FAIL rst_busy: got %b want 0", busy); end
    total++; if (done !== 1'b0)   begin bad++; $display("FAIL rst_done: got %b want 0", done); end
    total++; if (mem_bus.mem_req !== 1'b0) begin bad++; $display("FAIL rst_mem_req: got %b want 0", mem_bus.mem_req); end
    total++; if (load_L !== 1'b1) begin bad++; $display("FAIL rst_load_L: got %b want 1", load_L); end
    total++; if (flt_start !== 1'b0) begin bad++; $display("FAIL rst_flt_start: got %b want 0", flt_start); end
    total++; if (pix_out !== 64'd0) begin bad++; $display("FAIL rst_pix_out: got %h want 0", pix_out); end
    total++; if (mem_bus.mem_addr !== 16'd0) begin bad++; $display("FAIL rst_mem_addr: got %h want 0", mem_bus.mem_addr); end
    total++; if (sel !== 8'd0)    begin bad++; $display("FAIL rst_sel: got %h want 0", sel); end
    reset_L = 1'b1;
    repeat (2) @(negedge clock);
  endtask

  task automatic test_frac_job();
    lat_mode = 0; spur_idx = -1;
    run_job(16'h0100, 2'd1, 2'd2, 3, 1'b0);
    total++; if (busy_after_start !== 1'b1) begin bad++; $display("FAIL frac_busy_rise: got %b want 1", busy_after_start); end
    total++; if (req_log.size() != 30) begin bad++; $display("FAIL frac_req_count: got %0d want 30", req_log.size()); end
    total++; if (req_cyc.size() == 0 || req_cyc[0] != start_cyc + 1) begin bad++; $display("FAIL frac_first_req_cycle: start at %0d, first req not at %0d", start_cyc, start_cyc + 1); end
    for (int i = 0; i < req_log.size(); i++) begin
      total++; if (req_log[i] !== exp_addr(16'h0100, 2'd2, i)) begin bad++; $display("FAIL frac_addr[%0d]: got %h want %h", i, req_log[i], exp_addr(16'h0100, 2'd2, i)); end
    end
    total++; if (load_log.size() != 30) begin bad++; $display("FAIL frac_load_count: got %0d want 30", load_log.size()); end
    for (int i = 0; i < load_log.size(); i++) begin
      total++; if (load_log[i] !== mem_word(exp_addr(16'h0100, 2'd2, i))) begin bad++; $display("FAIL frac_pix[%0d]: got %h want %h", i, load_log[i], mem_word(exp_addr(16'h0100, 2'd2, i))); end
      if (i > 0) begin
        total++; if (load_cyc[i] - load_cyc[i-1] != 3) begin bad++; $display("FAIL frac_load_gap[%0d]: got %0d want 3", i, load_cyc[i] - load_cyc[i-1]); end
      end
    end
    total++; if (flt_cnt != 1) begin bad++; $display("FAIL frac_flt_count: got %0d want 1", flt_cnt); end
    if (load_cyc.size() > 0) begin
      total++; if (flt_start_cyc != load_cyc[load_cyc.size()-1] + 1) begin bad++; $display("FAIL frac_flt_start_cycle: got %0d want %0d", flt_start_cyc, load_cyc[load_cyc.size()-1] + 1); end
    end
    total++; if (sel_at_flt !== 8'h09) begin bad++; $display("FAIL frac_sel: got %h want 09", sel_at_flt); end
    total++; if (done_cyc != flt_done_cyc + 1) begin bad++; $display("FAIL frac_done_cycle: got %0d want %0d", done_cyc, flt_done_cyc + 1); end
    total++; if (done_cyc != start_cyc + 90 + 1 + 3 + 1) begin bad++; $display("FAIL frac_job_length: got %0d want %0d", done_cyc - start_cyc, 95); end
    total++; if (busy_after_done !== 1'b0) begin bad++; $display("FAIL frac_busy_fall: got %b want 0", busy_after_done); end
    total++; if (sel !== 8'h09) begin bad++; $display("FAIL frac_sel_hold: got %h want 09", sel); end
  endtask

  task automatic test_frac_y0();
    lat_mode = 0; spur_idx = -1;
    run_job(16'h0200, 2'd2, 2'd0, 0, 1'b0);
    total++; if (req_log.size() != 16) begin bad++; $display("FAIL y0_req_count: got %0d want 16", req_log.size()); end
    for (int i = 0; i < req_log.size(); i++) begin
      total++; if (req_log[i] !== exp_addr(16'h0200, 2'd0, i)) begin bad++; $display("FAIL y0_addr[%0d]: got %h want %h", i, req_log[i], exp_addr(16'h0200, 2'd0, i)); end
    end
    total++; if (load_log.size() != 16) begin bad++; $display("FAIL y0_load_count: got %0d want 16", load_log.size()); end
    for (int i = 0; i < load_log.size(); i++) begin
      total++; if (load_log[i] !== mem_word(exp_addr(16'h0200, 2'd0, i))) begin bad++; $display("FAIL y0_pix[%0d]: got %h want %h", i, load_log[i], mem_word(exp_addr(16'h0200, 2'd0, i))); end
    end
    total++; if (sel_at_flt !== 8'h02) begin bad++; $display("FAIL y0_sel: got %h want 02", sel_at_flt); end
    total++; if (done_cyc != start_cyc + 48 + 1 + 0 + 1) begin bad++; $display("FAIL y0_job_length: got %0d want %0d", done_cyc - start_cyc, 50); end
  endtask

  task automatic test_var_latency();
    lat_mode = 1; spur_idx = -1;
    run_job(16'h0300, 2'd3, 2'd1, 2, 1'b0);
    total++; if (overlap_cnt != 0) begin bad++; $display("FAIL lat_req_overlap: got %0d want 0", overlap_cnt); end
    total++; if (req_log.size() != 30) begin bad++; $display("FAIL lat_req_count: got %0d want 30", req_log.size()); end
    total++; if (load_log.size() != 30) begin bad++; $display("FAIL lat_load_count: got %0d want 30", load_log.size()); end
    for (int i = 0; i < load_log.size(); i++) begin
      total++; if (load_log[i] !== mem_word(exp_addr(16'h0300, 2'd1, i))) begin bad++; $display("FAIL lat_pix[%0d]: got %h want %h", i, load_log[i], mem_word(exp_addr(16'h0300, 2'd1, i))); end
      if (i > 0) begin
        total++; if (load_cyc[i] - load_cyc[i-1] < 2) begin bad++; $display("FAIL lat_load_gap[%0d]: got %0d want >=2", i, load_cyc[i] - load_cyc[i-1]); end
      end
    end
    total++; if (sel_at_flt !== 8'h07) begin bad++; $display("FAIL lat_sel: got %h want 07", sel_at_flt); end
    lat_mode = 0;
  endtask

  task automatic test_busy_start();
    lat_mode = 0; spur_idx = 5;
    run_job(16'h0400, 2'd0, 2'd3, 1, 1'b1);
    spur_idx = -1;
    total++; if (load_log.size() != 30) begin bad++; $display("FAIL busy_load_count: got %0d want 30", load_log.size()); end
    for (int i = 0; i < req_log.size(); i++) begin
      total++; if (req_log[i] !== exp_addr(16'h0400, 2'd3, i)) begin bad++; $display("FAIL busy_addr[%0d]: got %h want %h", i, req_log[i], exp_addr(16'h0400, 2'd3, i)); end
    end
    for (int i = 0; i < load_log.size(); i++) begin
      total++; if (load_log[i] !== mem_word(exp_addr(16'h0400, 2'd3, i))) begin bad++; $display("FAIL busy_pix[%0d]: got %h want %h", i, load_log[i], mem_word(exp_addr(16'h0400, 2'd3, i))); end
    end
    repeat (5) @(negedge clock);
    total++; if (req_log.size() != 30) begin bad++; $display("FAIL busy_no_queue: got %0d requests want 30", req_log.size()); end
    total++; if (busy !== 1'b0) begin bad++; $display("FAIL busy_idle_after: got %b want 0", busy); end
    total++; if (done_cnt != 1) begin bad++; $display("FAIL busy_done_count: got %0d want 1", done_cnt); end
  endtask

  task automatic test_addr_wrap();
    lat_mode = 0; spur_idx = -1;
    run_job(16'hFFF0, 2'd0, 2'd1, 1, 1'b0);
    total++; if (req_log.size() != 30) begin bad++; $display("FAIL wrap_req_count: got %0d want 30", req_log.size()); end
    for (int i = 0; i < req_log.size(); i++) begin
      total++; if (req_log[i] !== exp_addr(16'hFFF0, 2'd1, i)) begin bad++; $display("FAIL wrap_addr[%0d]: got %h want %h", i, req_log[i], exp_addr(16'hFFF0, 2'd1, i)); end
    end
    if (req_log.size() > 16) begin
      total++; if (req_log[16] !== 16'h0000) begin bad++; $display("FAIL wrap_zero: got %h want 0000", req_log[16]); end
    end
  endtask

  task automatic test_reset_mid();
    lat_mode = 2; spur_idx = -1; flt_delay = 1;
    launch(16'h0500, 2'd3, 2'd2);
    for (int k = 0; k < 500 && req_log.size() < 12; k++) @(negedge clock);
    total++; if (req_log.size() != 12) begin bad++; $display("FAIL rmid_reach_beat11: got %0d requests want 12", req_log.size()); end
    @(negedge clock);
    reset_L = 1'b0;
    #1;
    total++; if (load_L !== 1'b1) begin bad++; $display("FAIL rmid_load_L: got %b want 1", load_L); end
    total++; if (busy !== 1'b0)   begin bad++; $display("FAIL rmid_busy: got %b want 0", busy); end
    total++; if (mem_bus.mem_req !== 1'b0) begin bad++; $display("FAIL rmid_mem_req: got %b want 0", mem_bus.mem_req); end
    repeat (2) @(negedge clock);
    reset_L = 1'b1;
    repeat (10) @(negedge clock);
    total++; if (load_log.size() != 11) begin bad++; $display("FAIL rmid_late_valid_load: got %0d loads want 11", load_log.size()); end
    total++; if (pix_out !== 64'd0) begin bad++; $display("FAIL rmid_late_valid_pix: got %h want 0", pix_out); end
    total++; if (busy !== 1'b0)   begin bad++; $display("FAIL rmid_idle: got %b want 0", busy); end
    lat_mode = 0;
    run_job(16'h0600, 2'd0, 2'd1, 1, 1'b0);
    total++; if (req_log.size() == 0 || req_log[0] !== 16'h0600) begin bad++; $display("FAIL rmid_restart_addr: got %h want 0600", (req_log.size() > 0) ? req_log[0] : 16'hxxxx); end
    total++; if (req_log.size() != 30) begin bad++; $display("FAIL rmid_restart_reqs: got %0d want 30", req_log.size()); end
    total++; if (load_log.size() != 30) begin bad++; $display("FAIL rmid_restart_loads: got %0d want 30", load_log.size()); end
  endtask

  initial begin
    test_reset();
    test_frac_job();
    test_frac_y0();
    test_var_latency();
    test_busy_start();
    test_addr_wrap();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
